// File: rtl/mips32_mem_dump_reader.sv
// Post-run data memory reader: after the core halts (or on a start request)
// reads word_count words starting at start_addr over a 1-cycle-latency read
// port and streams them out on a valid/ready port with address and last flag.
module mips32_mem_dump_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int AUTO_TRIG  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_addr,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [NW-1:0]       count_q, count_d;
  logic [NW-1:0]       issued_q, issued_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   infl_addr_q, infl_addr_d;
  logic                infl_last_q, infl_last_d;
  logic                halted_prev_q, halted_prev_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;

  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic                fifo_last_q [FIFO_DEPTH];

  logic                trig;
  logic                push;
  logic                pop;
  logic                head_last;
  logic                room;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CW:0]         occ;

  assign dout_valid = (fifo_cnt_q != '0);
  assign head_last  = fifo_last_q[rd_ptr_q];
  assign dout_data  = dout_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign dout_addr  = dout_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign dout_last  = dout_valid & head_last;
  assign pop        = dout_valid & dout_ready;
  assign push       = inflight_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_FIN);
  assign mem_rd_en  = rd_en;
  assign mem_addr   = rd_en ? rd_addr : '0;

  // Next-state, read issue and FIFO bookkeeping; a slot is only requested when
  // the buffered words plus the read in flight, net of this cycle's pop, leave room.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    issued_d      = issued_q;
    inflight_d    = 1'b0;
    infl_addr_d   = infl_addr_q;
    infl_last_d   = infl_last_q;
    halted_prev_d = halted;
    rd_en         = 1'b0;
    rd_addr       = base_q + issued_q[ADDR_W-1:0];
    trig          = start | ((AUTO_TRIG != 0) & halted & ~halted_prev_q);
    occ           = {1'b0, fifo_cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    room          = (occ < (CW+1)'(FIFO_DEPTH));

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          base_d   = start_addr;
          count_d  = word_count;
          issued_d = '0;
          state_d  = (word_count == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if ((issued_q < count_q) && room) begin
          rd_en       = 1'b1;
          issued_d    = issued_q + NW'(1);
          inflight_d  = 1'b1;
          infl_addr_d = rd_addr;
          infl_last_d = (issued_q == count_q - NW'(1));
        end
        if (pop && head_last) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
  end

  // Control state; reset drops any read in flight so late data is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      inflight_q    <= 1'b0;
      halted_prev_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      inflight_q    <= inflight_d;
      halted_prev_q <= halted_prev_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Datapath: tag of the read in flight and FIFO storage, captured on return.
  always_ff @(posedge clk) begin
    infl_addr_q <= infl_addr_d;
    infl_last_q <= infl_last_d;
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
      fifo_addr_q[wr_ptr_q] <= infl_addr_q;
      fifo_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

endmodule
